// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : watch_pkg
//  Description : Shared definitions for the watch timekeeper: mode-select
//                encodings, reset time/alarm values, BCD digit width and the
//                hour-to-display conversion helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package watch_pkg;

  localparam int BCD_W  = 4;
  localparam int HOUR_W = 5;

  typedef enum logic [1:0] {
    SEL_TSET = 2'b00,
    SEL_ASET = 2'b01,
    SEL_HOLD = 2'b10,
    SEL_RUN  = 2'b11
  } sel_t;

  localparam logic [HOUR_W-1:0] RST_HOUR           = 5'd12;
  localparam logic [BCD_W-1:0]  RST_MIN_TENS       = 4'd0;
  localparam logic [BCD_W-1:0]  RST_MIN_ONES       = 4'd0;
  localparam logic [BCD_W-1:0]  RST_SEC_TENS       = 4'd0;
  localparam logic [BCD_W-1:0]  RST_SEC_ONES       = 4'd0;
  localparam logic [HOUR_W-1:0] RST_ALARM_HOUR     = 5'd6;
  localparam logic [BCD_W-1:0]  RST_ALARM_MIN_TENS = 4'd0;
  localparam logic [BCD_W-1:0]  RST_ALARM_MIN_ONES = 4'd0;

  // Binary hour (0..23) to two BCD digits {tens, ones}.
  // 12-hour view: 0 shows as 12, 13..23 fold down to 1..11.
  function automatic logic [2*BCD_W-1:0] hour_to_bcd(input logic [HOUR_W-1:0] hour,
                                                     input logic              mode24);
    logic [HOUR_W-1:0] h;
    logic [BCD_W-1:0]  tens;
    logic [BCD_W-1:0]  ones;
    h = hour;
    if (!mode24) begin
      if (hour == 5'd0) begin
        h = 5'd12;
      end else if (hour > 5'd12) begin
        h = hour - 5'd12;
      end
    end
    if (h >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(h - 5'd20);
    end else if (h >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(h - 5'd10);
    end else begin
      tens = 4'd0;
      ones = 4'(h);
    end
    return {tens, ones};
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_sync_edge
//  Description : Multi-stage synchroniser for an asynchronous button followed
//                by a rising-edge detector. One press gives exactly one
//                single-cycle pulse; a held button gives no further pulses.
//  Revision    : 1.0 - initial release
//  Ports       : clk     - clock
//                rst_n   - asynchronous active-low reset
//                i_btn   - raw asynchronous button
//                o_pulse - one-cycle pulse on a synchronised rising edge
// ============================================================================
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/watch_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module      : watch_timekeeper
//  Description : 24-hour timekeeper with prescaler, button time/alarm setting,
//                12/24-hour BCD display and a one-shot alarm pulse.
//  Revision    : 1.0 - initial release
//  Ports       : clk100MHz         - clock
//                rst_n             - asynchronous active-low reset
//                sel[1:0]          - 00 time-set, 01 alarm-set, 10 hold, 11 run
//                minbtn/tenminbtn/hrbtn - raw setting buttons
//                mode24            - 1 = 24-hour display, 0 = 12-hour display
//                alarm_en          - alarm enable
//                tenhrout..onesecout - registered BCD display digits
//                pm                - internal hour is 12..23
//                tick1s            - one-cycle pulse per elapsed second
//                alarm             - one-cycle alarm pulse
// ============================================================================
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk100MHz,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic             minbtn,
  input  logic             tenminbtn,
  input  logic             hrbtn,
  input  logic             mode24,
  input  logic             alarm_en,
  output logic [BCD_W-1:0] tenhrout,
  output logic [BCD_W-1:0] onehrout,
  output logic [BCD_W-1:0] tenminout,
  output logic [BCD_W-1:0] oneminout,
  output logic [BCD_W-1:0] tensecout,
  output logic [BCD_W-1:0] onesecout,
  output logic             pm,
  output logic             tick1s,
  output logic             alarm
);

  localparam int              PW          = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   c_presc_max = PW'(CLK_HZ - 1);

  logic [PW-1:0]      r_presc;
  logic [HOUR_W-1:0]  r_hour;
  logic [BCD_W-1:0]   r_min_t, r_min_o, r_sec_t, r_sec_o;
  logic [HOUR_W-1:0]  r_al_hour;
  logic [BCD_W-1:0]   r_al_min_t, r_al_min_o;
  logic [BCD_W-1:0]   r_tenhr, r_onehr, r_tenmin, r_onemin, r_tensec, r_onesec;
  logic               r_pm, r_tick1s, r_alarm;

  sel_t               w_sel;
  logic               w_e_min, w_e_tmin, w_e_hr, w_any;
  logic               w_act_min, w_act_tmin;
  logic               w_tset, w_aset, w_tick_raw, w_tick;
  logic [2*BCD_W-1:0] w_hour_bcd;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_min (
    .clk(clk100MHz), .rst_n(rst_n), .i_btn(minbtn),    .o_pulse(w_e_min));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tmin (
    .clk(clk100MHz), .rst_n(rst_n), .i_btn(tenminbtn), .o_pulse(w_e_tmin));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hr (
    .clk(clk100MHz), .rst_n(rst_n), .i_btn(hrbtn),     .o_pulse(w_e_hr));

  assign w_sel      = sel_t'(sel);
  assign w_any      = w_e_min | w_e_tmin | w_e_hr;
  // Priority minbtn > tenminbtn > hrbtn; hour action is the fall-through case.
  assign w_act_min  = w_e_min;
  assign w_act_tmin = w_e_tmin & ~w_e_min;
  assign w_tset     = w_any & (w_sel == SEL_TSET);
  assign w_aset     = w_any & (w_sel == SEL_ASET);
  assign w_tick_raw = (r_presc == c_presc_max) && (w_sel != SEL_HOLD);
  // A time-set action overrides a coincident tick.
  assign w_tick     = w_tick_raw & ~w_tset;
  assign w_hour_bcd = hour_to_bcd(r_hour, mode24);

  // Prescaler: frozen in hold, restarted by a time-set action.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_sel == SEL_HOLD) begin
      r_presc <= r_presc;
    end else if (w_tset || w_tick_raw) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Time of day.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_hour  <= RST_HOUR;
      r_min_t <= RST_MIN_TENS;
      r_min_o <= RST_MIN_ONES;
      r_sec_t <= RST_SEC_TENS;
      r_sec_o <= RST_SEC_ONES;
    end else if (w_tset) begin
      if (w_act_min) begin
        r_min_o <= (r_min_o == 4'd9) ? 4'd0 : r_min_o + 4'd1;
      end else if (w_act_tmin) begin
        r_min_t <= (r_min_t == 4'd5) ? 4'd0 : r_min_t + 4'd1;
      end else begin
        r_hour  <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
      end
      r_sec_t <= 4'd0;
      r_sec_o <= 4'd0;
    end else if (w_tick) begin
      if (r_sec_o != 4'd9) begin
        r_sec_o <= r_sec_o + 4'd1;
      end else begin
        r_sec_o <= 4'd0;
        if (r_sec_t != 4'd5) begin
          r_sec_t <= r_sec_t + 4'd1;
        end else begin
          r_sec_t <= 4'd0;
          if (r_min_o != 4'd9) begin
            r_min_o <= r_min_o + 4'd1;
          end else begin
            r_min_o <= 4'd0;
            if (r_min_t != 4'd5) begin
              r_min_t <= r_min_t + 4'd1;
            end else begin
              r_min_t <= 4'd0;
              r_hour  <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
            end
          end
        end
      end
    end
  end

  // Alarm time.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_al_hour  <= RST_ALARM_HOUR;
      r_al_min_t <= RST_ALARM_MIN_TENS;
      r_al_min_o <= RST_ALARM_MIN_ONES;
    end else if (w_aset) begin
      if (w_act_min) begin
        r_al_min_o <= (r_al_min_o == 4'd9) ? 4'd0 : r_al_min_o + 4'd1;
      end else if (w_act_tmin) begin
        r_al_min_t <= (r_al_min_t == 4'd5) ? 4'd0 : r_al_min_t + 4'd1;
      end else begin
        r_al_hour  <= (r_al_hour == 5'd23) ? 5'd0 : r_al_hour + 5'd1;
      end
    end
  end

  // Registered outputs. The alarm is qualified by the registered tick so it
  // lines up with the display showing the matching HH:MM:00.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_tenhr  <= 4'd1;
      r_onehr  <= 4'd2;
      r_tenmin <= 4'd0;
      r_onemin <= 4'd0;
      r_tensec <= 4'd0;
      r_onesec <= 4'd0;
      r_pm     <= 1'b1;
      r_tick1s <= 1'b0;
      r_alarm  <= 1'b0;
    end else begin
      r_tenhr  <= w_hour_bcd[2*BCD_W-1:BCD_W];
      r_onehr  <= w_hour_bcd[BCD_W-1:0];
      r_tenmin <= r_min_t;
      r_onemin <= r_min_o;
      r_tensec <= r_sec_t;
      r_onesec <= r_sec_o;
      r_pm     <= (r_hour >= 5'd12);
      r_tick1s <= w_tick;
      r_alarm  <= r_tick1s && alarm_en &&
                  (r_hour == r_al_hour) && (r_min_t == r_al_min_t) &&
                  (r_min_o == r_al_min_o) && (r_sec_t == 4'd0) && (r_sec_o == 4'd0);
    end
  end

  assign tenhrout  = r_tenhr;
  assign onehrout  = r_onehr;
  assign tenminout = r_tenmin;
  assign oneminout = r_onemin;
  assign tensecout = r_tensec;
  assign onesecout = r_onesec;
  assign pm        = r_pm;
  assign tick1s    = r_tick1s;
  assign alarm     = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_watch_timekeeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_watch_timekeeper
//  Description : Scoreboard bench for watch_timekeeper. A seconds-of-day
//                reference model predicts the registered outputs each cycle;
//                a monitor pops and compares. Directed checks cover rollover,
//                12/24-hour mapping, button priority, alarm and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_watch_timekeeper;
  import watch_pkg::*;

  localparam int CLK_HZ = 10;
  localparam int SS     = 3;

  typedef struct packed {
    logic [3:0] th, oh, tm, om, ts, os;
    logic       pm, tick, alarm;
  } exp_t;

  logic       clk100MHz = 1'b0;
  logic       rst_n;
  logic [1:0] sel;
  logic       minbtn, tenminbtn, hrbtn, mode24, alarm_en;
  logic [3:0] tenhrout, onehrout, tenminout, oneminout, tensecout, onesecout;
  logic       pm, tick1s, alarm;

  always #5 clk100MHz = ~clk100MHz;

  watch_timekeeper #(.CLK_HZ(CLK_HZ), .SYNC_STAGES(SS)) dut (
    .clk100MHz(clk100MHz), .rst_n(rst_n), .sel(sel),
    .minbtn(minbtn), .tenminbtn(tenminbtn), .hrbtn(hrbtn),
    .mode24(mode24), .alarm_en(alarm_en),
    .tenhrout(tenhrout), .onehrout(onehrout), .tenminout(tenminout),
    .oneminout(oneminout), .tensecout(tensecout), .onesecout(onesecout),
    .pm(pm), .tick1s(tick1s), .alarm(alarm));

  // ---------------- reference model ----------------
  exp_t q[$];
  exp_t m_out;
  int   m_tsec, m_am, m_presc;
  bit   m_sh[3][SS];
  bit   m_prev[3];
  int   checks = 0, errors = 0, n_alarm = 0, cyc = 0;

  function automatic exp_t reset_out();
    return {4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic model_reset();
    m_tsec  = 12 * 3600;
    m_am    = 6 * 60;
    m_presc = 0;
    for (int b = 0; b < 3; b++) begin
      m_prev[b] = 1'b0;
      for (int i = 0; i < SS; i++) m_sh[b][i] = 1'b0;
    end
    m_out = reset_out();
  endtask

  // Apply one button action to a minutes-of-day value.
  function automatic int adj(input int hm, input bit pmin, input bit ptmin, input bit phr);
    int h, m;
    h = hm / 60;
    m = hm % 60;
    if (pmin)       m = m - (m % 10) + ((m % 10) + 1) % 10;
    else if (ptmin) m = (((m / 10) + 1) % 6) * 10 + (m % 10);
    else if (phr)   h = (h + 1) % 24;
    return h * 60 + m;
  endfunction

  task automatic model_step();
    bit   p[3];
    bit   cur[3];
    bit   tick_raw, tset, aset, any;
    int   h, mi, s, hd;
    exp_t n;
    if (!rst_n) begin
      model_reset();
      q.push_back(m_out);
      return;
    end
    cur[0] = minbtn; cur[1] = tenminbtn; cur[2] = hrbtn;
    for (int b = 0; b < 3; b++) begin
      p[b] = m_sh[b][SS-1] & ~m_prev[b];
      m_prev[b] = m_sh[b][SS-1];
      for (int i = SS - 1; i > 0; i--) m_sh[b][i] = m_sh[b][i-1];
      m_sh[b][0] = cur[b];
    end
    tick_raw = (m_presc == CLK_HZ - 1) && (sel != SEL_HOLD);
    any      = p[0] | p[1] | p[2];
    tset     = any && (sel == SEL_TSET);
    aset     = any && (sel == SEL_ASET);
    h  = m_tsec / 3600;
    mi = (m_tsec / 60) % 60;
    s  = m_tsec % 60;
    hd = mode24 ? h : ((h % 12 == 0) ? 12 : h % 12);
    n.th = 4'(hd / 10);  n.oh = 4'(hd % 10);
    n.tm = 4'(mi / 10);  n.om = 4'(mi % 10);
    n.ts = 4'(s / 10);   n.os = 4'(s % 10);
    n.pm    = (h >= 12);
    n.alarm = m_out.tick && alarm_en && (m_tsec == m_am * 60);
    n.tick  = tick_raw && !tset;
    m_out = n;
    if (tset) begin
      m_tsec  = adj(m_tsec / 60, p[0], p[1], p[2]) * 60;
      m_presc = 0;
    end else begin
      if (tick_raw) m_tsec = (m_tsec + 1) % 86400;
      if (sel != SEL_HOLD) m_presc = tick_raw ? 0 : m_presc + 1;
    end
    if (aset) m_am = adj(m_am, p[0], p[1], p[2]);
    q.push_back(m_out);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk100MHz);
      #1;
      cyc++;
      if (q.size() != 0) begin
        e = q.pop_front();
        a = {tenhrout, onehrout, tenminout, oneminout, tensecout, onesecout, pm, tick1s, alarm};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %h want %h (th oh tm om ts os pm tick alarm)", cyc, a, e);
        end
        if (alarm === 1'b1) n_alarm++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    model_step();
    @(negedge clk100MHz);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       minbtn    = v;
      1:       tenminbtn = v;
      default: hrbtn     = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1); steps(4);
    set_btn(b, 1'b0); steps(4);
  endtask

  task automatic set_time(input int h, input int m);
    sel = SEL_TSET;
    for (int k = 0; k < 30 && (m_tsec / 3600) != h; k++)            press(2);
    for (int k = 0; k < 10 && ((m_tsec / 600) % 6) != m / 10; k++)  press(1);
    for (int k = 0; k < 12 && ((m_tsec / 60) % 10) != m % 10; k++)  press(0);
  endtask

  task automatic set_alarm(input int h, input int m);
    sel = SEL_ASET;
    for (int k = 0; k < 30 && (m_am / 60) != h; k++)            press(2);
    for (int k = 0; k < 10 && ((m_am / 10) % 6) != m / 10; k++) press(1);
    for (int k = 0; k < 12 && (m_am % 10) != m % 10; k++)       press(0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int a0;
    rst_n = 1'b0; sel = SEL_RUN; minbtn = 1'b0; tenminbtn = 1'b0; hrbtn = 1'b0;
    mode24 = 1'b0; alarm_en = 1'b0;
    model_reset();
    @(negedge clk100MHz);
    chk("reset_outputs", int'({tenhrout, onehrout, tenminout, oneminout, tensecout, onesecout, pm, tick1s, alarm}),
        int'(reset_out()));
    steps(2);
    rst_n = 1'b1;
    steps(25);

    // 23:59:59 -> 00:00:00 in both display modes
    set_time(23, 59);
    sel = SEL_RUN;
    for (int k = 0; k < 700 && m_tsec != 0; k++) step();
    step();
    chk("rollover_12h_disp", int'({tenhrout, onehrout, tenminout, oneminout, tensecout, onesecout}), 'h120000);
    chk("rollover_12h_pm", int'(pm), 0);
    mode24 = 1'b1;
    step();
    chk("rollover_24h_disp", int'({tenhrout, onehrout, tenminout, oneminout, tensecout, onesecout}), 'h000000);
    steps(5);

    // hour 13 in both modes; one-minute digit wrap without carry
    set_time(13, 9);
    mode24 = 1'b1; step();
    chk("h13_24h", int'({tenhrout, onehrout}), 'h13);
    chk("h13_24h_pm", int'(pm), 1);
    mode24 = 1'b0; step();
    chk("h13_12h", int'({tenhrout, onehrout}), 'h01);
    chk("h13_12h_pm", int'(pm), 1);
    press(0);
    chk("minwrap_ones", int'(oneminout), 0);
    chk("minwrap_tens", int'(tenminout), 0);

    // simultaneous minbtn + hrbtn: minute wins, seconds cleared
    minbtn = 1'b1; hrbtn = 1'b1; steps(4);
    minbtn = 1'b0; hrbtn = 1'b0; steps(4);
    chk("simul_min", int'({tenminout, oneminout}), 'h01);
    chk("simul_hour", int'({tenhrout, onehrout}), 'h01);
    chk("simul_sec", int'({tensecout, onesecout}), 'h00);

    // alarm at 06:01, enabled then disabled
    set_alarm(6, 1);
    set_time(6, 0);
    alarm_en = 1'b1; sel = SEL_RUN; a0 = n_alarm;
    steps(640);
    chk("alarm_enabled_count", n_alarm - a0, 1);
    set_time(6, 0);
    alarm_en = 1'b0; sel = SEL_RUN; a0 = n_alarm;
    steps(640);
    chk("alarm_disabled_count", n_alarm - a0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel       = 2'($urandom_range(0, 3));
      minbtn    = ($urandom_range(0, 3) == 0);
      tenminbtn = ($urandom_range(0, 3) == 0);
      hrbtn     = ($urandom_range(0, 3) == 0);
      if (i % 8 == 0) mode24 = 1'($urandom_range(0, 1));
      alarm_en  = 1'($urandom_range(0, 1));
      step();
    end
    minbtn = 1'b0; tenminbtn = 1'b0; hrbtn = 1'b0;

    // hold
    sel = SEL_HOLD;
    steps(50);

    // asynchronous reset mid-count
    sel = SEL_RUN;
    steps(13);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'({tenhrout, onehrout, tenminout, oneminout, tensecout, onesecout, pm, tick1s, alarm}),
        int'(reset_out()));
    model_reset();
    @(negedge clk100MHz);
    steps(3);
    rst_n = 1'b1;
    steps(25);

    @(posedge clk100MHz);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/watch_timekeeper.md
WATCH_TIMEKEEPER -- requirements
Module: watch_timekeeper

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: clk100MHz cycles per second; legal range 2 .. 2^27.
REQ-002 Parameter SYNC_STAGES, default 2: button synchroniser depth; legal range 2..4.
REQ-003 Port clk100MHz, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port sel, input, 2: mode select. 00 = time-set, 01 = alarm-set, 10 = hold, 11 = run with buttons ignored.
REQ-006 Ports minbtn, tenminbtn, hrbtn, input, 1 each: raw asynchronous active-high buttons.
REQ-007 Port mode24, input, 1: 1 = 24-hour display, 0 = 12-hour display.
REQ-008 Port alarm_en, input, 1: alarm enable.
REQ-009 Ports tenhrout, onehrout, tenminout, oneminout, tensecout, onesecout, output, 4 each: displayed time, BCD.
REQ-010 Port pm, output, 1: 1 when the internal hour is 12..23; valid in both display modes.
REQ-011 Port tick1s, output, 1: one-cycle pulse per elapsed second.
REQ-012 Port alarm, output, 1: one-cycle alarm pulse.

Function
REQ-013 Internal time SHALL be an hour register (binary 0..23), two minute BCD digits and two second BCD digits.
REQ-014 Prescaler:
- Counts 0..CLK_HZ-1 and wraps to 0.
- Raises an internal tick in the cycle the count equals CLK_HZ-1.
- Frozen when sel=10.
REQ-015 Each tick SHALL advance the time by one second with full carry:
- Seconds 59 -> 00 carries into minutes.
- Minutes 59 -> 00 carries into the hour.
- Hour 23 -> 0.
REQ-016 Each button SHALL pass through a SYNC_STAGES synchroniser followed by a rising-edge detector; one press = one action, and a held button never repeats.
REQ-017 With sel=00, button actions adjust the time:
- minbtn: one-minute digit +1, 9 -> 0, no carry.
- tenminbtn: ten-minute digit +1, 5 -> 0, no carry.
- hrbtn: hour +1 modulo 24.
- Every applied action also clears the seconds and the prescaler.
REQ-018 With sel=01:
- The same button actions adjust the alarm hour/minute registers.
- Timekeeping continues unaffected.
REQ-019 With sel=10 or sel=11, button edges SHALL be discarded.
REQ-020 Simultaneous edges: only one action is applied, priority minbtn > tenminbtn > hrbtn.
REQ-021 A button action in the same cycle as a tick SHALL win; that tick is discarded.
REQ-022 Display mapping:
- mode24=1: the hour is shown as two BCD digits 00..23.
- mode24=0: hour 0 -> 12, hours 1..12 unchanged, hours 13..23 -> 1..11.
REQ-023 All outputs SHALL be registered with one cycle of latency from the internal state or tick; a mode24 change is reflected on the next cycle.
REQ-024 alarm SHALL pulse for one cycle, one cycle after the tick that makes the time equal alarm hour:minute:00, and only if alarm_en=1; it does not fire on a time-set action.

Reset
REQ-025 While rst_n=0, the block SHALL hold the following reset state:
- Time 12:00:00 (hour 12).
- Alarm 06:00.
- Prescaler 0 and synchronisers/edge detectors 0.
- Outputs 1,2,0,0,0,0 with pm=1, tick1s=0, alarm=0.
REQ-026 Reset assertion mid-operation SHALL force the reset state immediately, without waiting for a clock edge. After release, the prescaler starts counting from 0 on the first clock edge.

Structure
REQ-027 Shared package watch_pkg SHALL hold:
- sel encodings (SEL_TSET, SEL_ASET, SEL_HOLD, SEL_RUN).
- Reset time and alarm constants.
- The BCD digit width.
REQ-028 Sub-module btn_sync_edge (parameter SYNC_STAGES; synchroniser plus rising-edge pulse) SHALL be instanced three times. All other logic lives in watch_timekeeper.

Verification (bench uses CLK_HZ=10)
REQ-029 Reset release with mode24=0 -> outputs 1,2,0,0,0,0, pm=1; first tick1s appears 10 cycles after release (+1 output latency).
REQ-030 Time 23:59:59, one tick -> internal 00:00:00:
- mode24=0: display 1,2,0,0,0,0 with pm=0.
- mode24=1: display 0,0,0,0,0,0.
REQ-031 Hour 13, mode24 toggled 1 -> 0 -> display changes 1,3 -> 0,1, pm=1 throughout; one-minute digit at 9 plus minbtn -> 0 and ten-minute digit unchanged.
REQ-032 minbtn and hrbtn rising in the same cycle, sel=00 -> only one-minute digit +1; hour unchanged; seconds cleared.
REQ-033 Alarm set to 06:01 via sel=01, run from 06:00:59 -> alarm high exactly one cycle, with display 06:01:00. Same run with alarm_en=0 -> no pulse.
REQ-034 Hold and reset behaviour:
- sel=10 for 50 cycles -> outputs constant and tick1s=0.
- rst_n pulsed low mid-count -> reset values asserted without waiting for a clock edge.
